// File: rtl/yuv422_apb_sequencer.sv
// yuv422_apb_sequencer
// APB master that feeds one 4-pixel YUV422 group into the YUV->RGB converter.
// It writes the two packed YUV words, waits for the converter's done irq, then
// reads back the four RGB results. Each result goes out on a valid/ready pixel
// stream, and m_last marks the fourth pixel.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | s_ready high, waiting for a YUV group
// WSETUP    | APB write setup phase (word w)
// WACCESS   | APB write access phase, waits on pready
// WAIT_DONE | bus idle, waiting for converter irq or timeout
// RSETUP    | APB read setup phase (pixel p)
// RACCESS   | APB read access phase, waits on pready
// OUT       | pixel p presented downstream until m_ready

module yuv422_apb_sequencer #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [63:0] s_data,
    output logic [31:0] paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr,
    input  logic        irq,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [23:0] m_data,
    output logic        m_last,
    output logic        busy,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] CODE_SLVERR  = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WSETUP    = 3'd1,
        WACCESS   = 3'd2,
        WAIT_DONE = 3'd3,
        RSETUP    = 3'd4,
        RACCESS   = 3'd5,
        OUT       = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      hi_word_q, hi_word_d;
    logic             w_q, w_d;
    logic [1:0]       p_q, p_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      paddr_q, paddr_d;
    logic [31:0]      pwdata_q, pwdata_d;
    logic [23:0]      m_data_q, m_data_d;
    logic             m_last_q, m_last_d;
    logic             m_valid_q, m_valid_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;

    // The low byte of the read word carries no pixel information.
    logic unused_prdata_lsb;
    assign unused_prdata_lsb = ^prdata[7:0];

    function automatic logic [31:0] rd_addr(input logic [1:0] idx);
        return BASE_ADDR + 32'h0000_0030 + {28'd0, idx, 2'b00};
    endfunction

    // APB control strobes are decoded from the registered state, so an async reset clears them at once.
    always_comb begin
        psel    = (state_q == WSETUP) || (state_q == WACCESS) ||
                  (state_q == RSETUP) || (state_q == RACCESS);
        penable = (state_q == WACCESS) || (state_q == RACCESS);
        pwrite  = (state_q == WSETUP) || (state_q == WACCESS);
        s_ready = (state_q == IDLE);
        busy    = (state_q != IDLE);
    end

    assign paddr    = paddr_q;
    assign pwdata   = pwdata_q;
    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign m_last   = m_last_q;
    assign err      = err_q;
    assign err_code = err_code_q;

    // Next-state logic. Address and write data are loaded on the transition into a setup phase,
    // so they stay stable through the whole access.
    always_comb begin
        state_d    = state_q;
        hi_word_d  = hi_word_q;
        w_d        = w_q;
        p_d        = p_q;
        cnt_d      = cnt_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        m_data_d   = m_data_q;
        m_last_d   = m_last_q;
        m_valid_d  = m_valid_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;

        unique case (state_q)
            IDLE: begin
                if (s_valid) begin
                    hi_word_d = s_data[63:32];
                    w_d       = 1'b0;
                    paddr_d   = BASE_ADDR + 32'h0000_0010;
                    pwdata_d  = s_data[31:0];
                    state_d   = WSETUP;
                end
            end
            WSETUP: begin
                state_d = WACCESS;
            end
            WACCESS: begin
                if (pready) begin
                    if (pslverr) begin
                        err_d      = 1'b1;
                        err_code_d = CODE_SLVERR;
                        state_d    = IDLE;
                    end else if (!w_q) begin
                        w_d      = 1'b1;
                        paddr_d  = BASE_ADDR + 32'h0000_0014;
                        pwdata_d = hi_word_q;
                        state_d  = WSETUP;
                    end else begin
                        cnt_d   = '0;
                        state_d = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                // irq takes priority over a timeout expiring in the same cycle
                if (irq) begin
                    p_d     = 2'd0;
                    paddr_d = rd_addr(2'd0);
                    state_d = RSETUP;
                end else if (cnt_q == CNT_LAST) begin
                    err_d      = 1'b1;
                    err_code_d = CODE_TIMEOUT;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RSETUP: begin
                state_d = RACCESS;
            end
            RACCESS: begin
                if (pready) begin
                    if (pslverr) begin
                        err_d      = 1'b1;
                        err_code_d = CODE_SLVERR;
                        state_d    = IDLE;
                    end else begin
                        m_data_d  = prdata[31:8];
                        m_last_d  = (p_q == 2'd3);
                        m_valid_d = 1'b1;
                        state_d   = OUT;
                    end
                end
            end
            OUT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    if (p_q == 2'd3) begin
                        state_d = IDLE;
                    end else begin
                        p_d     = p_q + 2'd1;
                        paddr_d = rd_addr(p_q + 2'd1);
                        state_d = RSETUP;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any group in flight.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q    <= IDLE;
            hi_word_q  <= '0;
            w_q        <= 1'b0;
            p_q        <= 2'd0;
            cnt_q      <= '0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            m_data_q   <= '0;
            m_last_q   <= 1'b0;
            m_valid_q  <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            hi_word_q  <= hi_word_d;
            w_q        <= w_d;
            p_q        <= p_d;
            cnt_q      <= cnt_d;
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            m_data_q   <= m_data_d;
            m_last_q   <= m_last_d;
            m_valid_q  <= m_valid_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

endmodule
